fifo_rd_ptr_empty: RTL

// Read-domain pointer/flag stage of the async Ethernet FIFO, directly downstream of sync_w2r.

---
 rtl/fifo_rd_ptr_empty.sv | 83 ++++++++
 1 files changed

// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and status stage of an async FIFO: binary/gray read pointer,
// RAM read address and registered empty / almost-empty / fill-level flags.
module fifo_rd_ptr_empty #(
   parameter int ADDR_WIDTH          = 4,
   parameter int ALMOST_EMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH:0]   i_wr_ptr_sync,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic [ADDR_WIDTH:0]   o_rd_ptr,
   output logic                  o_empty,
   output logic                  o_almost_empty,
   output logic [ADDR_WIDTH:0]   o_rd_level
);

   localparam int PW = ADDR_WIDTH + 1;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Binary bit i is the XOR of all gray bits at or above i.
   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b = g;
      for (int i = 1; i < PW; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   logic [PW-1:0]         r_rd_bin;
   logic [PW-1:0]         r_rd_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic                  r_empty;
   logic                  r_almost_empty;
   logic [PW-1:0]         r_rd_level;

   logic                  w_rd_acc;
   logic [PW-1:0]         w_rd_bin_nxt;
   logic [PW-1:0]         w_rd_gray_nxt;
   logic [PW-1:0]         w_wr_bin;
   logic [PW-1:0]         w_level_nxt;
   logic                  w_empty_nxt;
   logic                  w_almost_nxt;

   assign w_rd_acc      = i_rd_en & ~r_empty;
   assign w_rd_bin_nxt  = r_rd_bin + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
   assign w_rd_gray_nxt = bin2gray(w_rd_bin_nxt);
   assign w_wr_bin      = gray2bin(i_wr_ptr_sync);
   // Modular subtraction keeps the level correct across pointer wrap.
   assign w_level_nxt   = w_wr_bin - w_rd_bin_nxt;
   assign w_empty_nxt   = (w_rd_gray_nxt == i_wr_ptr_sync);
   assign w_almost_nxt  = (w_level_nxt <= PW'(ALMOST_EMPTY_THRESH));

   // Pointer and status registers, all updated from the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_bin       <= {PW{1'b0}};
         r_rd_ptr       <= {PW{1'b0}};
         r_rd_addr      <= {ADDR_WIDTH{1'b0}};
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         r_rd_level     <= {PW{1'b0}};
      end else begin
         r_rd_bin       <= w_rd_bin_nxt;
         r_rd_ptr       <= w_rd_gray_nxt;
         r_rd_addr      <= w_rd_bin_nxt[ADDR_WIDTH-1:0];
         r_empty        <= w_empty_nxt;
         r_almost_empty <= w_almost_nxt;
         r_rd_level     <= w_level_nxt;
      end
   end

   assign o_rd_addr      = r_rd_addr;
   assign o_rd_ptr       = r_rd_ptr;
   assign o_empty        = r_empty;
   assign o_almost_empty = r_almost_empty;
   assign o_rd_level     = r_rd_level;

endmodule
